// File: rtl/hwag_angle_sched_if.sv
// Shadow-register write bus for the angle scheduler.
// The master drives the write, and the slave returns the reject pulse.
interface hwag_angle_sched_if #(
  parameter int CHW = 2,
  parameter int AW  = 24
);
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic           wr_stop;
  logic [AW-1:0]  wr_data;
  logic           wr_err;

  modport master (output wr_en, output wr_ch, output wr_stop, output wr_data, input wr_err);
  modport slave  (input wr_en, input wr_ch, input wr_stop, input wr_data, output wr_err);
endinterface

// File: rtl/hwag_angle_sched.sv
// Angle-domain output scheduler: each channel drives its output from a start angle to a stop angle.
// The start and stop angles come from the ACNT2 counter. They are double-buffered, and a commit happens only outside an active pulse.
module hwag_angle_sched #(
  parameter int NCH       = 4,
  parameter int CHW       = 2,
  parameter int AW        = 24,
  parameter int ANGLE_TOP = 3839
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hwag_start,
  input  logic [AW-1:0]           angle,
  input  logic                    angle_step,
  input  logic [NCH-1:0]          ch_ena,
  hwag_angle_sched_if.slave       wr_bus,
  output logic [NCH-1:0]          ch_out,
  output logic [NCH-1:0]          ch_done,
  output logic [NCH-1:0]          ch_pend,
  output logic                    sync_err
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE
  } ch_state_t;

  localparam logic [AW-1:0] TOP_VAL = AW'(ANGLE_TOP);
  localparam logic [CHW:0]  NCH_VAL = (CHW+1)'(NCH);

  ch_state_t     state      [NCH];
  logic [AW-1:0] shadow_start [NCH];
  logic [AW-1:0] shadow_stop  [NCH];
  logic [AW-1:0] start_act  [NCH];
  logic [AW-1:0] stop_act   [NCH];

  logic           wr_ok;
  logic           wr_bad;
  logic [CHW:0]   wr_ch_x;
  logic [NCH-1:0] commit;
  logic [NCH-1:0] run;
  logic           any_active;

  // A commit is allowed only outside a pulse, so an in-flight pulse always ends on its original stop angle.
  always_comb begin
    wr_ch_x    = {1'b0, wr_bus.wr_ch};
    wr_ok      = wr_bus.wr_en && (wr_bus.wr_data <= TOP_VAL) && (wr_ch_x < NCH_VAL);
    wr_bad     = wr_bus.wr_en && !wr_ok;
    any_active = 1'b0;
    commit     = '0;
    run        = '0;
    for (int i = 0; i < NCH; i++) begin
      commit[i]  = ch_pend[i] && (state[i] != ACTIVE);
      run[i]     = ch_ena[i] && hwag_start;
      any_active = any_active | (state[i] == ACTIVE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_out        <= '0;
      ch_done       <= '0;
      ch_pend       <= '0;
      sync_err      <= 1'b0;
      wr_bus.wr_err <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        state[i]        <= IDLE;
        shadow_start[i] <= '0;
        shadow_stop[i]  <= '0;
        start_act[i]    <= '0;
        stop_act[i]     <= '0;
      end
    end else begin
      wr_bus.wr_err <= wr_bad;
      sync_err      <= !hwag_start && any_active;
      for (int i = 0; i < NCH; i++) begin
        ch_done[i] <= 1'b0;

        if (commit[i]) begin
          start_act[i] <= shadow_start[i];
          stop_act[i]  <= shadow_stop[i];
          ch_pend[i]   <= 1'b0;
        end

        // A write in the same cycle comes after the commit, so the new data stays pending.
        if (wr_ok && (wr_bus.wr_ch == CHW'(i))) begin
          if (wr_bus.wr_stop) shadow_stop[i]  <= wr_bus.wr_data;
          else                shadow_start[i] <= wr_bus.wr_data;
          ch_pend[i] <= 1'b1;
        end

        if (!run[i]) begin
          state[i]  <= IDLE;
          ch_out[i] <= 1'b0;
        end else begin
          case (state[i])
            IDLE: state[i] <= ARMED;
            ARMED: begin
              // A cycle with a commit skips the compare, so the next compare sees the new values.
              if (!commit[i] && angle_step && (angle == start_act[i]) &&
                  (start_act[i] != stop_act[i])) begin
                state[i]  <= ACTIVE;
                ch_out[i] <= 1'b1;
              end
            end
            ACTIVE: begin
              if (angle_step && (angle == stop_act[i])) begin
                state[i]   <= ARMED;
                ch_out[i]  <= 1'b0;
                ch_done[i] <= 1'b1;
              end
            end
            default: begin
              state[i]  <= IDLE;
              ch_out[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hwag_angle_sched.sv
// Directed bench for hwag_angle_sched. A flag-based reference model is checked against the DUT on every cycle.
// Hand-computed pulse positions are also checked, which pins the model itself.
module tb_hwag_angle_sched;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int AW  = 24;
  localparam int TOP = 3839;

  logic           clk = 1'b0;
  logic           rst;
  logic           hwag_start;
  logic [AW-1:0]  angle;
  logic           angle_step;
  logic [NCH-1:0] ch_ena;
  logic [NCH-1:0] ch_out, ch_done, ch_pend;
  logic           sync_err;

  hwag_angle_sched_if #(.CHW(CHW), .AW(AW)) bus ();

  hwag_angle_sched #(.NCH(NCH), .CHW(CHW), .AW(AW), .ANGLE_TOP(TOP)) dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .angle(angle),
    .angle_step(angle_step), .ch_ena(ch_ena), .wr_bus(bus.slave),
    .ch_out(ch_out), .ch_done(ch_done), .ch_pend(ch_pend), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // The reference model tracks, per channel, whether the channel saw a live enable last cycle and whether it is mid-pulse.
  int       m_sh_start [NCH];
  int       m_sh_stop  [NCH];
  int       m_start    [NCH];
  int       m_stop     [NCH];
  bit [NCH-1:0] m_pend, m_live, m_high, exp_done;
  bit       exp_werr, exp_serr;
  bit       model_live = 0;
  bit       may_commit, live_now;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_sh_start[c] = 0; m_sh_stop[c] = 0; m_start[c] = 0; m_stop[c] = 0;
      end
      m_pend = '0; m_live = '0; m_high = '0; exp_done = '0;
      exp_werr = 0; exp_serr = 0;
      model_live = 1;
    end else begin
      exp_serr = !hwag_start && (m_high != '0);
      exp_werr = bus.wr_en && (int'(bus.wr_data) > TOP);
      exp_done = '0;
      for (int c = 0; c < NCH; c++) begin
        may_commit = m_pend[c] && !m_high[c];
        live_now   = ch_ena[c] && hwag_start;
        if (!live_now) begin
          m_live[c] = 0;
          m_high[c] = 0;
        end else if (!m_live[c]) begin
          m_live[c] = 1;
        end else if (!m_high[c]) begin
          if (!may_commit && angle_step && int'(angle) == m_start[c] && m_start[c] != m_stop[c])
            m_high[c] = 1;
        end else if (angle_step && int'(angle) == m_stop[c]) begin
          m_high[c]   = 0;
          exp_done[c] = 1;
        end
        if (may_commit) begin
          m_start[c] = m_sh_start[c];
          m_stop[c]  = m_sh_stop[c];
          m_pend[c]  = 0;
        end
        if (bus.wr_en && int'(bus.wr_data) <= TOP && int'(bus.wr_ch) == c) begin
          if (bus.wr_stop) m_sh_stop[c] = int'(bus.wr_data);
          else             m_sh_start[c] = int'(bus.wr_data);
          m_pend[c] = 1;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      cmp("model ch_out",   ch_out,  m_high);
      cmp("model ch_done",  ch_done, exp_done);
      cmp("model ch_pend",  ch_pend, m_pend);
      cmp("model wr_err",   {3'b0, bus.wr_err}, {3'b0, exp_werr});
      cmp("model sync_err", {3'b0, sync_err},   {3'b0, exp_serr});
    end
  end

  task automatic check_output(input string name, input int act, input int req);
    total_cnt++;
    if (act != req) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  int cur_angle = TOP;
  int hi_cnt, first_hi, last_hi, done_cnt, done_ang;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply n consecutive angle strobes and record when the tracked channel is high or done.
  task automatic apply_stimulus(input int n, input int ch);
    hi_cnt = 0; first_hi = -1; last_hi = -1; done_cnt = 0; done_ang = -1;
    for (int k = 0; k < n; k++) begin
      cur_angle  = (cur_angle == TOP) ? 0 : cur_angle + 1;
      angle      = AW'(cur_angle);
      angle_step = 1'b1;
      tick();
      if (ch_out[ch]) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = cur_angle;
        last_hi = cur_angle;
      end
      if (ch_done[ch]) begin
        done_cnt++;
        done_ang = cur_angle;
      end
    end
    angle_step = 1'b0;
  endtask

  task automatic write_shadow(input int ch, input bit stop, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = CHW'(ch);
    bus.wr_stop = stop;
    bus.wr_data = AW'(data);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hwag_start = 1'b0; angle = '0; angle_step = 1'b0; ch_ena = '0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_stop = 1'b0; bus.wr_data = '0;
    tick(); tick();
    check_output("reset ch_out",   int'(ch_out), 0);
    check_output("reset ch_pend",  int'(ch_pend), 0);
    check_output("reset sync_err", int'(sync_err), 0);
    rst = 1'b0;

    // Basic pulse on ch0.
    write_shadow(0, 0, 100);
    write_shadow(0, 1, 200);
    tick();
    hwag_start = 1'b1; ch_ena = 4'b0001;
    tick(); tick();
    apply_stimulus(301, 0);
    check_output("basic hi_cnt", hi_cnt, 100);
    check_output("basic first", first_hi, 100);
    check_output("basic last", last_hi, 199);
    check_output("basic done_cnt", done_cnt, 1);
    check_output("basic done_ang", done_ang, 200);

    // Deferred commit: rewrite during the pulse at angle 150.
    apply_stimulus(3690, 0);
    check_output("defer mid high", int'(ch_out[0]), 1);
    write_shadow(0, 0, 500);
    write_shadow(0, 1, 600);
    check_output("defer pend held", int'(ch_pend[0]), 1);
    apply_stimulus(50, 0);
    check_output("defer old stop", done_ang, 200);
    check_output("defer pend at stop", int'(ch_pend[0]), 1);
    tick();
    check_output("defer pend cleared", int'(ch_pend[0]), 0);
    apply_stimulus(500, 0);
    check_output("defer new first", first_hi, 500);
    check_output("defer new last", last_hi, 599);
    check_output("defer new done", done_ang, 600);

    // Wrap pulse on ch1.
    write_shadow(1, 0, 3800);
    write_shadow(1, 1, 40);
    ch_ena = 4'b0011;
    tick(); tick();
    apply_stimulus(3099, 1);
    apply_stimulus(100, 1);
    check_output("wrap hi_cnt", hi_cnt, 80);
    check_output("wrap first", first_hi, 3800);
    check_output("wrap last", last_hi, 39);
    check_output("wrap done_ang", done_ang, 40);
    check_output("wrap done_cnt", done_cnt, 1);

    // Rejected write, then the degenerate zero-width channel.
    write_shadow(0, 0, 3840);
    check_output("reject wr_err", int'(bus.wr_err), 1);
    check_output("reject pend", int'(ch_pend[0]), 0);
    tick();
    check_output("reject wr_err gone", int'(bus.wr_err), 0);
    write_shadow(2, 0, 50);
    write_shadow(2, 1, 50);
    ch_ena = 4'b0111;
    tick(); tick();
    apply_stimulus(3840, 2);
    check_output("degen hi_cnt", hi_cnt, 0);
    check_output("degen done_cnt", done_cnt, 0);

    // Sync loss mid-pulse on ch0.
    write_shadow(0, 0, 100);
    write_shadow(0, 1, 200);
    tick();
    apply_stimulus(91, 0);
    check_output("sync mid high", int'(ch_out[0]), 1);
    hwag_start = 1'b0;
    tick();
    check_output("sync out low", int'(ch_out[0]), 0);
    check_output("sync err pulse", int'(sync_err), 1);
    check_output("sync no done", int'(ch_done[0]), 0);
    tick();
    check_output("sync err gone", int'(sync_err), 0);
    hwag_start = 1'b1;
    tick(); tick();
    apply_stimulus(3940, 0);
    check_output("resync first", first_hi, 100);
    check_output("resync hi_cnt", hi_cnt, 100);
    check_output("resync done_cnt", done_cnt, 1);

    // Reset mid-pulse with a deferred write outstanding.
    apply_stimulus(3740, 0);
    check_output("rst mid high", int'(ch_out[0]), 1);
    write_shadow(0, 0, 700);
    rst = 1'b1;
    tick();
    check_output("rst ch_out", int'(ch_out), 0);
    check_output("rst ch_pend", int'(ch_pend), 0);
    rst = 1'b0;

    // Collision: the second write lands in the cycle where the first one commits.
    ch_ena = 4'b0000;
    write_shadow(0, 0, 300);
    write_shadow(0, 1, 400);
    check_output("collide pend", int'(ch_pend[0]), 1);
    tick();
    check_output("collide pend cleared", int'(ch_pend[0]), 0);
    ch_ena = 4'b0001;
    tick(); tick();
    apply_stimulus(300, 0);
    check_output("collide first", first_hi, 300);
    check_output("collide last", last_hi, 399);
    check_output("collide done", done_ang, 400);

    tick();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
